// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO and memory-mapped status register.
//
// Receives 11-bit PS/2 frames (start, 8 data bits LSB first, odd parity, stop),
// queues good bytes in a FIFO and exposes them on a combinational read bus.
//
// Ports:
//   system_clk  - single system clock, all state updates on rising edge
//   reset       - synchronous, active-high
//   PS2_clk     - asynchronous PS/2 clock line
//   PS2_data    - asynchronous PS/2 data line
//   address     - read address
//   read        - read strobe; pops at DATA_ADDRESS, clears sticky state at STATUS_ADDRESS
//   data        - read data (head byte or status word), zero for other addresses
module ps2_keyboard_fifo #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDRESS = 14'h3fff,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDRESS = 14'h3ffe,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  system_clk,
  input  logic                  reset,
  input  logic                  PS2_clk,
  input  logic                  PS2_data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronisers; the extra clock history flop turns a falling edge into a one-cycle event.
  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_data_meta_q, ps2_data_sync_q;
  logic sample;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
    end else begin
      ps2_clk_meta_q  <= PS2_clk;
      ps2_clk_sync_q  <= ps2_clk_meta_q;
      ps2_clk_prev_q  <= ps2_clk_sync_q;
      ps2_data_meta_q <= PS2_data;
      ps2_data_sync_q <= ps2_data_meta_q;
    end
  end

  assign sample = ps2_clk_prev_q & ~ps2_clk_sync_q;

  // Frame receiver
  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_ok_q, parity_ok_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               frame_done, frame_valid, timeout;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    frame_done  = 1'b0;
    frame_valid = 1'b0;
    timeout     = 1'b0;

    if (sample) begin
      unique case (state_q)
        StIdle: begin
          if (!ps2_data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          // Shift right so the first (LSB) bit ends up in bit 0 after eight samples.
          shift_d   = {ps2_data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_ok_d = ^{shift_q, ps2_data_sync_q};
          state_d     = StStop;
        end
        StStop: begin
          frame_done  = 1'b1;
          frame_valid = ps2_data_sync_q & parity_ok_q;
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && timer_q == TimerW'(TIMEOUT_CYCLES)) begin
      timeout = 1'b1;
      state_d = StIdle;
    end

    if (sample || timeout || state_q == StIdle) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      timer_q     <= timer_d;
    end
  end

  // FIFO and sticky status
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      err_count_q, err_count_d;
  logic            overflow_q, overflow_d;
  logic            empty, full, pop, push, overflow_set, err_inc, status_rd;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CntW'(FIFO_DEPTH));
  assign pop          = read && (address == DATA_ADDRESS) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push         = frame_valid && (!full || pop);
  assign overflow_set = frame_valid && full && !pop;
  assign err_inc      = (frame_done && !frame_valid) || timeout;
  assign status_rd    = read && (address == STATUS_ADDRESS);

  always_comb begin
    err_count_d = err_count_q;
    overflow_d  = overflow_q;
    if (status_rd) begin
      err_count_d = '0;
      overflow_d  = 1'b0;
    end
    // A new event wins over a clear in the same cycle.
    if (err_inc) begin
      if (status_rd) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hff) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      err_count_q <= err_count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Read mux
  always_comb begin
    data = '0;
    if (address == DATA_ADDRESS) begin
      if (!empty) begin
        data[7:0] = mem_q[rd_ptr_q];
      end
    end else if (address == STATUS_ADDRESS) begin
      data[0]     = empty;
      data[1]     = full;
      data[2]     = overflow_q;
      data[15:8]  = 8'(count_q);
      data[23:16] = err_count_q;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Bench for ps2_keyboard_fifo: directed scenarios plus randomized frames.
// The stimulus process drives the PS/2 lines and pushes expectations; a monitor
// process owns the read bus, serves queued checks and drains the FIFO against a
// byte scoreboard.
module tb_ps2_keyboard_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 1000;
  localparam int unsigned HALF  = 10;
  localparam logic [13:0] DATA_A = 14'h3fff;
  localparam logic [13:0] STAT_A = 14'h3ffe;

  logic        system_clk;
  logic        reset;
  logic        PS2_clk;
  logic        PS2_data;
  logic [13:0] address;
  logic        read;
  logic [63:0] data;

  ps2_keyboard_fifo #(
    .ADDR_WIDTH(14),
    .DATA_WIDTH(64),
    .DATA_ADDRESS(DATA_A),
    .STATUS_ADDRESS(STAT_A),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clk(system_clk),
    .reset(reset),
    .PS2_clk(PS2_clk),
    .PS2_data(PS2_data),
    .address(address),
    .read(read),
    .data(data)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [13:0] addr;
    logic        rd;
    logic [63:0] exp;
  } req_t;

  req_t       req_q[$];
  string      name_q[$];
  logic [7:0] sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int issued   = 0;
  bit drain_en = 1'b0;
  bit mon_busy = 1'b0;

  // Reference model state
  bit m_ovf = 1'b0;
  int m_err = 0;

  function automatic logic [63:0] stat(bit e, bit f, bit o, int c, int er);
    logic [63:0] v;
    v        = '0;
    v[0]     = e;
    v[1]     = f;
    v[2]     = o;
    v[15:8]  = 8'(c);
    v[23:16] = 8'(er);
    return v;
  endfunction

  // ---------------- monitor: sole owner of the read bus ----------------
  task automatic bus_op(input logic [13:0] a, input logic rd, output logic [63:0] d);
    address = a;
    read    = rd;
    #1;
    d = data;
    @(posedge system_clk);
    #1;
    read    = 1'b0;
    address = '0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    req_t        r;
    string       nm;
    logic [63:0] d;
    address = '0;
    read    = 1'b0;
    forever begin
      @(negedge system_clk);
      if (req_q.size() != 0) begin
        mon_busy = 1'b1;
        r  = req_q.pop_front();
        nm = name_q.pop_front();
        bus_op(r.addr, r.rd, d);
        check(nm, d, r.exp);
        done_cnt++;
        mon_busy = 1'b0;
      end else if (drain_en) begin
        mon_busy = 1'b1;
        bus_op(STAT_A, 1'b0, d);
        if (!d[0]) begin
          @(negedge system_clk);
          bus_op(DATA_A, 1'b1, d);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fifo_extra: got byte %h, expected no byte", d[7:0]);
          end else begin
            check("fifo_byte", d, {56'd0, sb.pop_front()});
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic post_check(input logic [13:0] a, input logic rd, input logic [63:0] e,
                            input string nm);
    req_t r;
    r.addr = a;
    r.rd   = rd;
    r.exp  = e;
    req_q.push_back(r);
    name_q.push_back(nm);
    issued++;
  endtask

  task automatic sync();
    int n = 0;
    while (done_cnt != issued && n < 500) begin
      @(negedge system_clk);
      n++;
    end
    if (done_cnt != issued) begin
      $display("FAIL sync_timeout: done %0d, expected %0d", done_cnt, issued);
      $fatal(1);
    end
  endtask

  task automatic exp_status(input logic rd, input string nm);
    post_check(STAT_A, rd, stat(sb.size() == 0, sb.size() == DEPTH, m_ovf, sb.size(), m_err), nm);
    if (rd) begin
      m_ovf = 1'b0;
      m_err = 0;
    end
    sync();
  endtask

  task automatic wait_drain();
    int n = 0;
    drain_en = 1'b1;
    while ((sb.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge system_clk);
      n++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: %0d bytes left, expected 0", sb.size());
      $fatal(1);
    end
    drain_en = 1'b0;
    n = 0;
    while (mon_busy && n < 20) begin
      @(negedge system_clk);
      n++;
    end
  endtask

  task automatic ps2_fall(input logic b);
    @(negedge system_clk);
    PS2_data = b;
    repeat (HALF) @(negedge system_clk);
    PS2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (HALF) @(negedge system_clk);
    PS2_clk = 1'b1;
  endtask

  // First n bits of a frame: start, 8 data bits LSB first, parity.
  task automatic send_bits(input logic [7:0] b, input logic par, input int n);
    logic [9:0] fr;
    fr = {par, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_fall(fr[i]);
      ps2_rise();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    bit valid;
    send_bits(b, par, 10);
    valid = stop && ((^b ^ par) == 1'b1);
    // Expectation is recorded before the stop edge so the monitor never sees a byte first.
    if (valid) begin
      if (!drain_en && sb.size() >= DEPTH) m_ovf = 1'b1;
      else sb.push_back(b);
    end else begin
      m_err = (m_err >= 255) ? 255 : m_err + 1;
    end
    ps2_fall(stop);
    ps2_rise();
  endtask

  initial begin : watchdog
    #(10 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main stimulus ----------------
  initial begin : stim
    logic [7:0] e;
    logic [7:0] b;
    logic       pe, se;
    reset    = 1'b1;
    PS2_clk  = 1'b1;
    PS2_data = 1'b1;
    repeat (3) @(posedge system_clk);
    @(negedge system_clk);
    reset = 1'b0;

    // Reset state and empty-pop boundary
    post_check(STAT_A, 1'b0, stat(1, 0, 0, 0, 0), "rst_status");
    post_check(DATA_A, 1'b0, 64'd0, "rst_data");
    post_check(14'h0123, 1'b0, 64'd0, "rst_other_addr");
    post_check(DATA_A, 1'b1, 64'd0, "pop_empty");
    sync();
    exp_status(1'b0, "after_pop_empty");

    // Single good frame 8'h1C with push latency
    send_bits(8'h1C, 1'b0, 10);
    ps2_fall(1'b1);
    @(posedge system_clk);
    @(posedge system_clk);
    #1;
    post_check(STAT_A, 1'b0, stat(1, 0, 0, 0, 0), "lat_before_push");
    post_check(STAT_A, 1'b0, stat(0, 0, 0, 1, 0), "lat_after_push");
    post_check(DATA_A, 1'b0, 64'h1C, "head_1c");
    sync();
    ps2_rise();
    sb.push_back(8'h1C);
    wait_drain();
    exp_status(1'b0, "t1_empty");

    // Parity error and clear-on-read
    send_frame(8'h1C, 1'b1, 1'b1);
    exp_status(1'b0, "perr_status");
    exp_status(1'b1, "perr_clear_read");
    exp_status(1'b0, "perr_cleared");

    // Overflow: DEPTH+1 bytes without reading
    for (int i = 1; i <= DEPTH + 1; i++) begin
      b = 8'(i);
      send_frame(b, ~^b, 1'b1);
    end
    exp_status(1'b0, "ovf_full");
    wait_drain();
    exp_status(1'b1, "ovf_drained_clear");
    exp_status(1'b0, "ovf_cleared");

    // Timeout after start + 3 data bits
    send_bits(8'hA5, 1'b0, 4);
    repeat (TMO + 100) @(negedge system_clk);
    m_err = m_err + 1;
    exp_status(1'b1, "timeout_err");
    exp_status(1'b0, "timeout_cleared");
    send_frame(8'hF0, ~^8'hF0, 1'b1);
    wait_drain();
    exp_status(1'b0, "after_f0");

    // Pop coinciding with push while full
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'h20 + 8'(i);
      send_frame(b, ~^b, 1'b1);
    end
    exp_status(1'b0, "pp_full");
    send_bits(8'h77, ~^8'h77, 10);
    ps2_fall(1'b1);
    @(posedge system_clk);
    @(posedge system_clk);
    #1;
    e = sb.pop_front();
    post_check(DATA_A, 1'b1, {56'd0, e}, "pop_at_push");
    sb.push_back(8'h77);
    sync();
    ps2_rise();
    exp_status(1'b0, "pp_still_full");
    wait_drain();
    exp_status(1'b0, "pp_empty");

    // Reset mid-frame
    send_bits(8'hC3, ~^8'hC3, 6);
    @(negedge system_clk);
    reset = 1'b1;
    @(posedge system_clk);
    @(posedge system_clk);
    @(negedge system_clk);
    reset = 1'b0;
    sb.delete();
    m_err = 0;
    m_ovf = 1'b0;
    exp_status(1'b0, "midreset_empty");
    send_frame(8'h5A, ~^8'h5A, 1'b1);
    exp_status(1'b0, "midreset_one");
    wait_drain();

    // Randomized frames with concurrent draining
    drain_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      pe = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 9) == 0);
      send_frame(b, (~^b) ^ pe, ~se);
      repeat ($urandom_range(0, 30)) @(negedge system_clk);
    end
    wait_drain();
    exp_status(1'b1, "rand_err_clear");
    exp_status(1'b0, "rand_final");

    sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Parametrised PS/2 keyboard receiver with a scan-code FIFO and a memory-mapped status register, the next generation of the single-byte keyboard peripheral. The block samples the asynchronous PS/2 clock and data lines in the system clock domain and validates each 11-bit frame (start, parity, stop). Valid bytes are queued in a FIFO that the CPU drains through two addresses on the 64-bit peripheral read bus. Frame errors, timeouts and overflow are counted or flagged instead of silently corrupting data.

## Interface
- ADDR_WIDTH, 14, width of address.
- DATA_WIDTH, 64, width of data; must be ≥ 24.
- DATA_ADDRESS, 14'h3fff, FIFO head / pop address.
- STATUS_ADDRESS, 14'h3ffe, status register address.
- FIFO_DEPTH, 16, entries; power of two, 2..128.
- TIMEOUT_CYCLES, 100000, system_clk cycles allowed between PS/2 bits inside a frame.

- system_clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- PS2_clk  in  1  asynchronous PS/2 clock line.
- PS2_data  in  1  asynchronous PS/2 data line.
- address  in  ADDR_WIDTH  read address.
- read  in  1  read strobe; qualifies pop and clear-on-read.
- data  out  DATA_WIDTH  read data, combinational from address and state.

## Operation
- Synchronisers: PS2_clk and PS2_data each pass through 2 flops. The clock path has a 3rd history flop. All of these flops reset to 1. A sample event is synchronised clk 1→0.
- FSM states: IDLE, DATA, PARITY, STOP. 3-bit bit counter; 8-bit shift register filled LSB first.
  - IDLE: a sample with data=0 moves to DATA with counter=0. A sample with data=1 is ignored.
  - DATA: shift in the bit. After the 8th bit, move to PARITY.
  - PARITY: parity_ok = XOR(8 data bits, parity bit) == 1 (odd parity). Move to STOP.
  - STOP: valid = stop bit 1 AND parity_ok. Move to IDLE.
    - Valid and FIFO not full: push the byte.
    - Valid and full: drop the byte and set the overflow sticky.
    - Invalid: drop the byte and increment err_count.
- Timeout: a counter clears on every sample event and counts while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial byte is discarded and err_count increments.
- err_count: 8 bits, saturates at 255.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap. count ranges 0..FIFO_DEPTH.
- Read mux (all other bits of data are 0):
  - address==DATA_ADDRESS: data[7:0] = head byte, or 0 when empty.
  - address==STATUS_ADDRESS: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count, bits[23:16] err_count.
  - any other address: data = 0. The bus is never tri-stated.
- Pop: read=1, address==DATA_ADDRESS and not empty. The pop takes effect at the next edge. A pop while empty is a no-op.
- Clear-on-read: read=1 with address==STATUS_ADDRESS clears overflow and err_count at the edge.
  - If an overflow or error event occurs in the same cycle, the set/increment wins: overflow=1, err_count=1.
- Simultaneous push and pop: both are performed and count is unchanged. This also applies when full; the push is accepted and overflow is not set.
- Reset: FSM to IDLE, pointers, count, err_count, overflow, shift register and timeout counter all 0. A frame in progress at reset is discarded.

## Timing
- Reset values: data = 0 unless address==STATUS_ADDRESS, in which case data = 24'h000001 (empty=1).
- Sample latency: a PS2_clk pin fall is seen as a sample event at the 3rd system_clk edge after it. The FSM acts at that edge.
- Push latency: the byte is visible on data and count increments in the cycle after the edge that processes the stop bit. This is 3 system_clk edges after the stop-bit PS2_clk fall.
- Read data has zero-cycle latency (combinational). Pop and clears take effect at the edge closing the cycle.
- The PS/2 clock period (60–100 µs) must exceed 6 system_clk cycles. Faster edges are unsupported.

## Test plan
- Reset, then send frame for 8'h1C (start 0, LSB first, parity 0, stop 1) → after 3 edges, DATA_ADDRESS reads 64'h1C and status count=1, empty=0.
- Frame 8'h1C with parity bit 1 → no push; status err_count=1, empty=1. A status read with read=1 then gives err_count=0.
- Send FIFO_DEPTH+1 valid bytes 8'h01..8'h11 without reading → full=1 and overflow=1. Popping 16 times returns 8'h01..8'h10 in order, then empty=1.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYCLES → FSM returns to IDLE and err_count=1. A following valid frame 8'hF0 is received correctly.
- Pop asserted in the same cycle as a push with count=FIFO_DEPTH → count stays FIFO_DEPTH, overflow stays 0, and the new byte appears last.
- Assert reset mid-frame (after 5 data bits), then send a full valid frame 8'h5A → only 8'h5A is queued and err_count=0.
